macc_drain: RTL
===============

# macc_drain

Downstream result stage for the pipelined multiply-accumulate unit. Counts accumulator updates and captures the accumulator value once every `len` updates, i.e. at the end of each dot product. It then rounds, right-shifts and saturates the value to the output width and buffers it in a small FIFO behind a valid/ready interface. It also pulses `acc_clear` so the upstream accumulator can restart the next dot product.

## Interface
- `ACC_WIDTH`, 40: accumulator width (unsigned).
- `OUT_WIDTH`, 16: result width.
- `SHIFT`, 8: right-shift applied before saturation; must satisfy 1 ≤ SHIFT < ACC_WIDTH.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `LEN_WIDTH`, 8: width of the dot-product length.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `acc_valid` in 1: `acc` holds a newly accumulated value this cycle.
- `acc` in ACC_WIDTH: accumulator value.
- `len` in LEN_WIDTH: updates per dot product; sampled when the update counter is 0; value 0 is treated as 1.
- `acc_clear` out 1: one-cycle pulse requesting the upstream accumulator to clear.
- `out_data` out OUT_WIDTH: FIFO head.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts the head when `out_valid` is high.
- `fifo_count` out clog2(DEPTH)+1: current occupancy.
- `sat_flag` out 1: sticky; set when any result saturated.
- `drop_flag` out 1: sticky; set when a result was lost because the FIFO was full.
- `flag_clr` in 1: synchronous clear of both sticky flags.

## Operation
- Update counter `cnt` (LEN_WIDTH bits):
  - On an `acc_valid` cycle with `cnt`=0, latch `len` (0→1) into `len_q`.
  - Each `acc_valid` increments `cnt`.
  - On the `acc_valid` where `cnt`+1 == `len_q` (the terminal update), capture `acc` into stage 1 and reset `cnt` to 0.
  - `acc_valid` low leaves `cnt` unchanged.
- Stage 1 (S1): `sum` = `acc` + 2^(SHIFT-1), width ACC_WIDTH+1 so the addition cannot overflow.
- Stage 2 (S2): `q` = `sum` >> SHIFT. If `q` > 2^OUT_WIDTH−1, the result is 2^OUT_WIDTH−1 and `sat_flag` is set; otherwise the result is `q`[OUT_WIDTH-1:0].
- FIFO write stage:
  - Push the S2 result.
  - If the FIFO is full and no pop occurs that cycle, discard the result and set `drop_flag`.
  - If full with a simultaneous pop, the push is accepted.
- Pop: occurs on any cycle with `out_valid` && `out_ready`; the head advances on that edge.
- `acc_clear` is registered and is high exactly in the cycle after the capture edge.
- Sticky flags:
  - `flag_clr` clears both flags.
  - If a set event and `flag_clr` occur in the same cycle, the set wins.
- Reset values: all outputs 0, `cnt`=0, FIFO empty, pipeline valids 0, `len_q`=1.
- Asynchronous reset mid-operation discards in-flight S1/S2 results and the FIFO contents.
- FIFO pointers wrap modulo DEPTH. `fifo_count` distinguishes full (DEPTH) from empty (0).

## Timing
- Capture edge E0 (terminal `acc_valid`) → S1 valid → S2 valid at E1 → FIFO write at E2.
- `out_valid` is high after E2 when the FIFO was empty: a latency of 3 edges from the terminal update.
- `acc_clear` is high between E0 and E1.
- Throughput: one capture per cycle (`len`=1 with continuous `acc_valid`) is sustained with no bubbles.
- `out_data` is registered, changes only at a pop or at a push into an empty FIFO, and is stable while `out_valid` && !`out_ready`.
- No combinational path from `out_ready` to `out_valid`/`out_data`; `acc` and `acc_valid` go only to registers.

## Configuration
- `MACC_DRAIN_ROUND_EN`:
  - Defined: S1 adds the half-LSB 2^(SHIFT-1), giving round-half-up.
  - Undefined: S1 passes `acc` unchanged (truncation); pipeline depth and latency are identical.
- All other behaviour is the same with and without the macro.

## Test plan
- Rounding: `len`=4, four `acc_valid` with `acc` = 0x10, 0x200, 0x900, 0x1280 → one result `out_data`=0x0013 (0x0012 without the macro). `out_valid` is high 3 edges after the 4th update. `acc_clear` pulses once.
- Saturation: `len`=1, `acc`=0x01_0000_0000 → `out_data`=0xFFFF and `sat_flag`=1. `flag_clr` then returns `sat_flag` to 0.
- Full FIFO: `out_ready`=0, `len`=1, five results 0x100, 0x200, 0x300, 0x400, 0x500 → `fifo_count`=4, `drop_flag`=1. Draining yields 0x01, 0x02, 0x03, 0x04 in order, then `out_valid`=0.
- Full with simultaneous pop: FIFO full, `out_ready`=1 on the same cycle a new result 0x600 arrives → `fifo_count` stays 4, `drop_flag` stays 0, and 0x06 emerges last.
- `len`=0 and back-to-back: `len`=0 with `acc_valid` held high for 3 cycles (`acc` = 0x100, 0x200, 0x300) → three results 0x01, 0x02, 0x03 on consecutive cycles and three `acc_clear` pulses.
- Reset mid-flight: assert `resetn`=0 asynchronously between E0 and E1 with 2 entries in the FIFO → all outputs are 0 immediately. After release, nothing is emitted until a new terminal update.

Source files
------------

// File: rtl/macc_drain.sv
// Result drain for the MAC unit: counts updates, captures every len-th accumulator value,
// rounds/shifts/saturates it and queues it in a small FIFO. Optional rounding: MACC_DRAIN_ROUND_EN.
module macc_drain #(
   parameter int ACC_WIDTH = 40,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT     = 8,
   parameter int DEPTH     = 4,
   parameter int LEN_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     acc_valid,
   input  logic [ACC_WIDTH-1:0]     acc,
   input  logic [LEN_WIDTH-1:0]     len,
   output logic                     acc_clear,
   output logic [OUT_WIDTH-1:0]     out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     sat_flag,
   output logic                     drop_flag,
   input  logic                     flag_clr
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [LEN_WIDTH-1:0] ONE_LEN = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ACC_WIDTH:0] MAX_Q = {{(ACC_WIDTH+1-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};
`ifdef MACC_DRAIN_ROUND_EN
   localparam logic [ACC_WIDTH:0] ROUND = (ACC_WIDTH+1)'(1) << (SHIFT-1);
`else
   localparam logic [ACC_WIDTH:0] ROUND = '0;
`endif

   logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, eff_len;
   logic                 terminal;
   logic                 s1_valid_q, s1_valid_d;
   logic [ACC_WIDTH:0]   s1_sum_q, s1_sum_d;
   logic [ACC_WIDTH:0]   shifted;
   logic                 sat;
   logic                 s2_valid_q, s2_valid_d;
   logic [OUT_WIDTH-1:0] s2_data_q, s2_data_d;
   logic                 acc_clear_q, acc_clear_d;
   logic [OUT_WIDTH-1:0] mem_q [DEPTH];
   logic [OUT_WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
   logic [PW:0]          count_q, count_d;
   logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic                 sat_q, sat_d, drop_q, drop_d;
   logic                 pop, push, full;

   always_comb begin
      cnt_d       = cnt_q;
      len_d       = len_q;
      s1_valid_d  = 1'b0;
      s1_sum_d    = s1_sum_q;
      s2_valid_d  = s1_valid_q;
      s2_data_d   = s2_data_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_data_d  = out_data_q;
      sat_d       = sat_q;
      drop_d      = drop_q;

      // A fresh dot product uses the live len so len=1 captures on its very first update
      eff_len = len_q;
      if (cnt_q == '0) eff_len = (len == '0) ? ONE_LEN : len;
      terminal = acc_valid && (({1'b0, cnt_q} + 1'b1) == {1'b0, eff_len});

      if (acc_valid) begin
         if (cnt_q == '0) len_d = eff_len;
         cnt_d = terminal ? '0 : cnt_q + 1'b1;
      end
      acc_clear_d = terminal;
      s1_valid_d  = terminal;
      if (terminal) s1_sum_d = {1'b0, acc} + ROUND;

      shifted = s1_sum_q >> SHIFT;
      sat     = shifted > MAX_Q;
      if (s1_valid_q) s2_data_d = sat ? '1 : shifted[OUT_WIDTH-1:0];

      full    = (count_q == FULL_CNT);
      pop     = (count_q != '0) && out_ready;
      push    = s2_valid_q && (!full || pop);
      rd_next = rd_ptr_q + 1'b1;

      if (push) begin
         mem_d[wr_ptr_q] = s2_data_q;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_next;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // The head register only moves on a pop or when the first entry lands in an empty FIFO
      if (pop && count_q > 1) out_data_d = mem_q[rd_next];
      else if (push && (count_q == '0 || (pop && count_q == 1))) out_data_d = s2_data_q;

      if (flag_clr) begin
         sat_d  = 1'b0;
         drop_d = 1'b0;
      end
      if (s1_valid_q && sat) sat_d = 1'b1;
      if (s2_valid_q && full && !pop) drop_d = 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q       <= '0;
         len_q       <= ONE_LEN;
         s1_valid_q  <= 1'b0;
         s1_sum_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_data_q   <= '0;
         acc_clear_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_data_q  <= '0;
         sat_q       <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         s1_valid_q  <= s1_valid_d;
         s1_sum_q    <= s1_sum_d;
         s2_valid_q  <= s2_valid_d;
         s2_data_q   <= s2_data_d;
         acc_clear_q <= acc_clear_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_data_q  <= out_data_d;
         sat_q       <= sat_d;
         drop_q      <= drop_d;
      end
   end

   assign acc_clear  = acc_clear_q;
   assign out_data   = out_data_q;
   assign out_valid  = (count_q != '0);
   assign fifo_count = count_q;
   assign sat_flag   = sat_q;
   assign drop_flag  = drop_q;

endmodule
